// File: rtl/perf_pkg.sv
// ============================================================================
// Module      : perf_pkg
// Description : Shared types and constants for the performance-counter bank.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package perf_pkg;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HALT = 1'b1
    } perf_state_t;

    localparam int CH_CYCLE  = 0;
    localparam int CH_BRANCH = 1;
    localparam int CH_JMP    = 2;

    localparam logic [31:0] DEF_CONT_CODE = 32'd34;

endpackage

`default_nettype wire

// File: rtl/perf_counter_chan.sv
// ============================================================================
// Module      : perf_counter_chan
// Description : One counter channel with sticky overflow, wrap or saturate.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module perf_counter_chan #(
    parameter int CNT_W = 32,
    parameter int SAT   = 0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    input  logic             clr_ch,
    output logic [CNT_W-1:0] count,
    output logic             ovf
);

    logic [CNT_W-1:0] r_count;
    logic             r_ovf;

    // A channel clear takes priority over an increment in the same cycle.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else if (clr_ch) begin
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else if (inc) begin
            if (&r_count) begin
                r_ovf <= 1'b1;
                if (SAT == 0) begin
                    r_count <= '0;
                end
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign count = r_count;
    assign ovf   = r_ovf;

endmodule

`default_nettype wire

// File: rtl/perf_counter_bank.sv
// ============================================================================
// Module      : perf_counter_bank
// Description : Cycle + event counter bank with syscall halt FSM, snapshot
//               shadows and a registered read port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module perf_counter_bank
    import perf_pkg::*;
#(
    parameter int          N_EVT     = 2,
    parameter int          CNT_W     = 32,
    parameter int          SAT       = 0,
    parameter logic [31:0] CONT_CODE = DEF_CONT_CODE
) (
    input  logic                         clk,
    input  logic                         clr,
    input  logic [N_EVT-1:0]             events,
    input  logic                         syscall,
    input  logic [31:0]                  r1,
    input  logic                         resume,
    input  logic [N_EVT:0]               chan_clr,
    input  logic                         snap,
    input  logic [$clog2(N_EVT+1)-1:0]   rd_sel,
    input  logic                         rd_en,
    output logic [CNT_W-1:0]             rd_data,
    output logic                         rd_valid,
    output logic [N_EVT:0]               ovf,
    output logic                         running
);

    localparam int N_CH  = N_EVT + 1;
    localparam int SEL_W = $clog2(N_CH);

    perf_state_t                r_state;
    perf_state_t                w_state_next;
    logic                       w_halt_req;
    logic                       w_running;
    logic [N_CH-1:0]            w_inc;
    logic [N_CH-1:0]            w_ovf;
    logic [N_CH-1:0][CNT_W-1:0] w_count;
    logic [N_CH-1:0][CNT_W-1:0] r_shadow;
    logic [CNT_W-1:0]           w_rd_mux;
    logic [CNT_W-1:0]           r_rd_data;
    logic                       r_rd_valid;

    // The halting syscall cycle itself is already not counted.
    assign w_halt_req = syscall && (r1 != CONT_CODE);
    assign w_running  = (r_state == RUN) && !w_halt_req;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            RUN:     if (w_halt_req) w_state_next = HALT;
            HALT:    if (resume)     w_state_next = RUN;
            default: w_state_next = RUN;
        endcase
    end

    assign w_inc = {events & {N_EVT{w_running}}, w_running};

    generate
        for (genvar c = 0; c < N_CH; c++) begin : g_chan
            perf_counter_chan #(
                .CNT_W (CNT_W),
                .SAT   (SAT)
            ) u_chan (
                .clk    (clk),
                .clr    (clr),
                .inc    (w_inc[c]),
                .clr_ch (chan_clr[c]),
                .count  (w_count[c]),
                .ovf    (w_ovf[c])
            );
        end
    endgenerate

    // Shadows capture the pre-update live values so all channels are coherent.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_shadow <= '0;
        end else if (snap) begin
            r_shadow <= w_count;
        end
    end

    // Out-of-range selects fall through to zero.
    always_comb begin
        w_rd_mux = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (rd_sel == SEL_W'(c)) begin
                w_rd_mux = r_shadow[c];
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= rd_en;
            if (rd_en) begin
                r_rd_data <= w_rd_mux;
            end
        end
    end

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    assign ovf      = w_ovf;
    assign running  = w_running;

endmodule

`default_nettype wire
